// File: rtl/alu_seq.sv
// alu_seq: handshaked 32-bit ALU with one-bit-per-cycle right shifts.
// Define ALU_SEQ_BARREL_EN to build single-cycle barrel shifts instead (no SHIFT state, no counter).
module alu_seq (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] A,
   input  logic [31:0] B,
   input  logic [2:0]  ALUOp,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] C,
   output logic        busy
);

`ifdef ALU_SEQ_BARREL_EN
   typedef enum logic [1:0] {IDLE = 2'd0, DONE = 2'd2} state_t;
`else
   typedef enum logic [1:0] {IDLE = 2'd0, SHIFT = 2'd1, DONE = 2'd2} state_t;
`endif

   state_t      state, state_next;
   logic [31:0] c_next;

`ifndef ALU_SEQ_BARREL_EN
   logic [31:0] acc, acc_next;
   logic [4:0]  cnt, cnt_next;
   logic        arith, arith_next;
   logic [31:0] shifted;

   // Arithmetic fill reuses acc[31], which always holds the sign latched from A.
   assign shifted = {(arith & acc[31]), acc[31:1]};
`endif

   always_comb begin
      state_next = state;
      c_next     = C;
`ifndef ALU_SEQ_BARREL_EN
      acc_next   = acc;
      cnt_next   = cnt;
      arith_next = arith;
`endif
      case (state)
         IDLE: begin
            if (in_valid) begin
               state_next = DONE;
               case (ALUOp)
                  3'd0: c_next = A + B;
                  3'd1: c_next = A - B;
                  3'd2: c_next = A & B;
                  3'd3: c_next = A | B;
`ifdef ALU_SEQ_BARREL_EN
                  3'd4: c_next = A >> B[4:0];
                  3'd5: c_next = $signed(A) >>> B[4:0];
`else
                  3'd4, 3'd5: begin
                     if (B[4:0] == 5'd0) begin
                        c_next = A;
                     end else begin
                        acc_next   = A;
                        cnt_next   = B[4:0];
                        arith_next = ALUOp[0];
                        state_next = SHIFT;
                     end
                  end
`endif
                  default: c_next = 32'd0;
               endcase
            end
         end
`ifndef ALU_SEQ_BARREL_EN
         SHIFT: begin
            acc_next = shifted;
            cnt_next = cnt - 5'd1;
            if (cnt == 5'd1) begin
               c_next     = shifted;
               state_next = DONE;
            end
         end
`endif
         DONE: begin
            if (out_ready) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         C     <= 32'd0;
`ifndef ALU_SEQ_BARREL_EN
         acc   <= 32'd0;
         cnt   <= 5'd0;
         arith <= 1'b0;
`endif
      end else begin
         state <= state_next;
         C     <= c_next;
`ifndef ALU_SEQ_BARREL_EN
         acc   <= acc_next;
         cnt   <= cnt_next;
         arith <= arith_next;
`endif
      end
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign busy      = (state != IDLE);

endmodule
